// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   fetch_state_e   - fetch FSM states
//   fetch_entry_t   - queue payload {pc, instr} at the default widths
//   PC_STEP         - byte increment between sequential instructions
//   pc_aligned()    - true when a target address is word aligned
package fetch_pkg;

   localparam int unsigned FETCH_ADDR_W    = 32;
   localparam int unsigned FETCH_INSTR_LEN = 32;
   localparam int unsigned PC_STEP         = 4;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      HALT  = 2'd1,
      FAULT = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [FETCH_ADDR_W-1:0]    pc;
      logic [FETCH_INSTR_LEN-1:0] instr;
   } fetch_entry_t;

   // Word alignment check on the two low address bits.
   function automatic logic pc_aligned(input logic [1:0] lsb);
      return (lsb == 2'b00);
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry synchronous FIFO holding fetched {pc, instr} entries.
//   clk, rst  - clock, synchronous active-high reset
//   push, din - write request and data (dropped when full without a pop)
//   pop       - read request (ignored when empty)
//   flush     - discard all entries; overrides push and pop
//   head_c    - oldest entry (zero after reset)
//   full_c    - queue holds DEPTH entries
//   count     - number of valid entries
module fetch_queue #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 64,
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head_c,
   output logic             full_c,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full_c = (count_q == CNT_W'(DEPTH));
   assign head_c = mem_q[rd_ptr_q];
   assign count  = count_q;

   // Push into a full queue is legal only when the head leaves the same cycle.
   always_comb begin
      do_pop   = pop && (count_q != '0);
      do_push  = push && (!full_c || do_pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage in front of a combinational instruction memory.
//   clk, rst          - clock, synchronous active-high reset
//   o_imem_addr       - memory read address (the PC register)
//   i_imem_data       - instruction word at o_imem_addr, same cycle
//   i_redirect_valid  - taken branch/jump: flush queue, load i_redirect_pc
//   i_halt            - stop fetching until reset
//   o_instr_valid/o_instr/o_instr_pc, i_instr_ready - decode handshake
//   o_fault           - sticky misaligned-redirect flag
//   o_halted          - fetch stopped (HALT or FAULT)
module instr_fetch
   import fetch_pkg::*;
#(
   parameter int unsigned        ADDR_W    = FETCH_ADDR_W,
   parameter int unsigned        INSTR_LEN = FETCH_INSTR_LEN,
   parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
   parameter int unsigned        Q_DEPTH   = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic [ADDR_W-1:0]    o_imem_addr,
   input  logic [INSTR_LEN-1:0] i_imem_data,
   input  logic                 i_redirect_valid,
   input  logic [ADDR_W-1:0]    i_redirect_pc,
   input  logic                 i_halt,
   output logic                 o_instr_valid,
   output logic [INSTR_LEN-1:0] o_instr,
   output logic [ADDR_W-1:0]    o_instr_pc,
   input  logic                 i_instr_ready,
   output logic                 o_fault,
   output logic                 o_halted
);

   localparam int unsigned ENTRY_W = ADDR_W + INSTR_LEN;
   localparam int unsigned CNT_W   = ((Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1) + 1;

   fetch_state_e        state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic                fault_q, fault_d;
   logic                halted_q, halted_d;

   logic [ENTRY_W-1:0]  q_head;
   logic                q_full;
   logic [CNT_W-1:0]    q_count;
   logic                q_push;
   logic                q_pop;
   logic                q_flush;
   logic                pop_req;

   fetch_queue #(
      .DEPTH (Q_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_queue (
      .clk    (clk),
      .rst    (rst),
      .push   (q_push),
      .pop    (q_pop),
      .flush  (q_flush),
      .din    ({pc_q, i_imem_data}),
      .head_c (q_head),
      .full_c (q_full),
      .count  (q_count)
   );

   assign o_imem_addr   = pc_q;
   assign o_instr_valid = (q_count != '0);
   assign o_instr_pc    = q_head[ENTRY_W-1:INSTR_LEN];
   assign o_instr       = q_head[INSTR_LEN-1:0];
   assign o_fault       = fault_q;
   assign o_halted      = halted_q;
   assign pop_req       = o_instr_valid && i_instr_ready;

   // Next state, PC and queue controls; redirect outranks halt and fetch.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      fault_d = fault_q;
      q_push  = 1'b0;
      q_pop   = pop_req;
      q_flush = 1'b0;
      unique case (state_q)
         RUN: begin
            if (i_redirect_valid) begin
               q_flush = 1'b1;
               q_pop   = 1'b0;
               if (pc_aligned(i_redirect_pc[1:0])) begin
                  pc_d    = i_redirect_pc;
                  state_d = i_halt ? HALT : RUN;
               end else begin
                  state_d = FAULT;
                  fault_d = 1'b1;
               end
            end else if (i_halt) begin
               state_d = HALT;
            end else if (!q_full || pop_req) begin
               q_push = 1'b1;
               pc_d   = pc_q + ADDR_W'(PC_STEP);
            end
         end
         HALT: begin
            // Queue keeps draining; PC frozen.
         end
         FAULT: begin
            q_flush = 1'b1;
            q_pop   = 1'b0;
         end
         default: begin
            state_d = FAULT;
            fault_d = 1'b1;
            q_flush = 1'b1;
            q_pop   = 1'b0;
         end
      endcase
      halted_d = (state_d != RUN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= RUN;
         pc_q     <= RESET_PC;
         fault_q  <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         fault_q  <= fault_d;
         halted_q <= halted_d;
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of instr_fetch against hand-computed values.
// Memory model: word at byte address A holds 0x100 + A/4.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;
   logic        fault;
   logic        halted;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   assign imem_data = 32'h100 + (imem_addr >> 2);

   instr_fetch #(
      .ADDR_W    (32),
      .INSTR_LEN (32),
      .RESET_PC  (32'h0),
      .Q_DEPTH   (2)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .o_imem_addr      (imem_addr),
      .i_imem_data      (imem_data),
      .i_redirect_valid (redirect_valid),
      .i_redirect_pc    (redirect_pc),
      .i_halt           (halt),
      .o_instr_valid    (instr_valid),
      .o_instr          (instr),
      .o_instr_pc       (instr_pc),
      .i_instr_ready    (instr_ready),
      .o_fault          (fault),
      .o_halted         (halted)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] data);
      check({tag, "_valid"}, 64'(instr_valid), 64'd1);
      check({tag, "_pc"}, 64'(instr_pc), 64'(pc));
      check({tag, "_instr"}, 64'(instr), 64'(data));
   endtask

   // Reset, then two fetches with decode stalled: queue full with 0 and 4.
   task automatic fill_queue();
      rst = 1'b1;
      instr_ready = 1'b0;
      redirect_valid = 1'b0;
      halt = 1'b0;
      step();
      rst = 1'b0;
      step();
      step();
   endtask

   initial begin
      rst = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      halt = 1'b0;
      instr_ready = 1'b1;
      step();
      step();

      // Reset values
      check("rst_valid", 64'(instr_valid), 64'd0);
      check("rst_instr", 64'(instr), 64'd0);
      check("rst_pc", 64'(instr_pc), 64'd0);
      check("rst_fault", 64'(fault), 64'd0);
      check("rst_halted", 64'(halted), 64'd0);
      check("rst_addr", 64'(imem_addr), 64'd0);

      // Streaming at full throughput
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check_head($sformatf("stream%0d", i), 32'(i * 4), 32'h100 + 32'(i));
      end

      // Backpressure: queue fills at two entries, PC parks at 8
      fill_queue();
      for (int i = 0; i < 3; i++) step();
      check("bp_addr", 64'(imem_addr), 64'h8);
      check_head("bp_head", 32'h0, 32'h100);
      instr_ready = 1'b1;
      for (int i = 1; i < 5; i++) begin
         step();
         check_head($sformatf("bp_rel%0d", i), 32'(i * 4), 32'h100 + 32'(i));
      end

      // Aligned redirect with a full queue
      fill_queue();
      instr_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h40;
      step();
      redirect_valid = 1'b0;
      check("redir_flush_valid", 64'(instr_valid), 64'd0);
      check("redir_addr", 64'(imem_addr), 64'h40);
      step();
      check_head("redir_tgt", 32'h40, 32'h110);
      step();
      check_head("redir_next", 32'h44, 32'h111);

      // Misaligned redirect: fault, no further output
      fill_queue();
      instr_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h42;
      step();
      redirect_valid = 1'b0;
      check("flt_fault", 64'(fault), 64'd1);
      check("flt_halted", 64'(halted), 64'd1);
      check("flt_valid", 64'(instr_valid), 64'd0);
      check("flt_addr", 64'(imem_addr), 64'h8);
      for (int i = 0; i < 3; i++) step();
      check("flt_valid_later", 64'(instr_valid), 64'd0);
      check("flt_fault_sticky", 64'(fault), 64'd1);

      // Halt with two entries queued: both still delivered
      fill_queue();
      halt = 1'b1;
      step();
      halt = 1'b0;
      check("halt_halted", 64'(halted), 64'd1);
      check_head("halt_head0", 32'h0, 32'h100);
      instr_ready = 1'b1;
      step();
      check_head("halt_head1", 32'h4, 32'h101);
      step();
      check("halt_drained", 64'(instr_valid), 64'd0);
      check("halt_addr", 64'(imem_addr), 64'h8);
      check("halt_still", 64'(halted), 64'd1);

      // Redirect and halt together: PC loaded, then halted
      fill_queue();
      instr_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h80;
      halt = 1'b1;
      step();
      redirect_valid = 1'b0;
      halt = 1'b0;
      check("rh_addr", 64'(imem_addr), 64'h80);
      check("rh_halted", 64'(halted), 64'd1);
      check("rh_fault", 64'(fault), 64'd0);
      step();
      check("rh_valid", 64'(instr_valid), 64'd0);

      // Reset mid-stream with the queue full (after a fault)
      fill_queue();
      redirect_valid = 1'b1;
      redirect_pc = 32'h6;
      step();
      redirect_valid = 1'b0;
      rst = 1'b1;
      step();
      check("mrst_valid", 64'(instr_valid), 64'd0);
      check("mrst_addr", 64'(imem_addr), 64'h0);
      check("mrst_fault", 64'(fault), 64'd0);
      check("mrst_halted", 64'(halted), 64'd0);
      rst = 1'b0;

      // PC wrap from the top of the address space
      instr_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      step();
      redirect_valid = 1'b0;
      check("wrap_addr0", 64'(imem_addr), 64'hFFFF_FFFC);
      step();
      check_head("wrap_top", 32'hFFFF_FFFC, 32'h4000_00FF);
      check("wrap_addr1", 64'(imem_addr), 64'h0);
      step();
      check_head("wrap_zero", 32'h0, 32'h100);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
